atomik_uart_tx_streamer: RTL
============================

ATOMIK_UART_TX_STREAMER -- requirements
Module: atomik_uart_tx_streamer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: word FIFO entries; power of two, 2..16.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port data_in  input  32  result word from core data_out.
REQ-007 SHALL have port data_valid  input  1  data_in qualifier from core data_ready.
REQ-008 SHALL have port data_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port uart_tx  output  1  serial line, idle high, 8N1.
REQ-010 SHALL have port tx_busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port overflow  output  1  sticky; word offered while data_ready low.

Function
REQ-012 SHALL use bit period DIV = CLK_FREQ/BAUD_RATE (integer floor; 234 at defaults), counted as DIV clk cycles per bit.
REQ-013 SHALL accept a word into the FIFO on any rising edge where data_valid and data_ready are both high.
REQ-014 SHALL drive data_ready as a registered ~full; data_ready is low when full, even if a pop occurs in the same cycle.
REQ-015 SHALL, on a same-cycle push and pop with the FIFO not full, leave occupancy unchanged and preserve word order.
REQ-016 SHALL set overflow on an edge where data_valid=1 and data_ready=0; the word is dropped; the flag holds until reset.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: on FIFO non-empty, SHALL pop the head word into a shift register, set byte_idx=0, and go to START.
REQ-019 START: SHALL drive uart_tx=0 for DIV cycles, then go to DATA.
REQ-020 DATA: SHALL send 8 bits of the current byte LSB first, DIV cycles each, then go to STOP.
REQ-021 STOP: SHALL drive uart_tx=1 for DIV cycles; if bytes remain, SHALL go to START with byte_idx+1, else to IDLE.
REQ-022 SHALL send the word's bytes in order [31:24], [23:16], [15:8], [7:0].
REQ-023 SHALL give latency of 2 clk edges from the acceptance edge into an empty FIFO with FSM in IDLE to the first uart_tx low edge.
REQ-024 SHALL send frames back-to-back: the next start bit directly follows a stop bit, with no extra idle cycle.
REQ-025 SHALL keep uart_tx registered and glitch-free, and high whenever in IDLE.
REQ-026 SHALL assert tx_busy from the edge after acceptance until the FSM returns to IDLE with the FIFO empty.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge: set FSM to IDLE, empty the FIFO, and force uart_tx=1, data_ready=0, tx_busy=0, overflow=0.
REQ-028 SHALL raise data_ready on the first edge after rst_n returns high.
REQ-029 SHALL, on reset mid-frame, abandon the frame; uart_tx is high on the reset edge, and no partial byte resumes after reset.

Configuration
REQ-030 SHALL, with macro ATOMIK_TX_CHECKSUM_EN defined, send a fifth byte after each word: XOR of its four bytes, framed like the others.
REQ-031 SHALL, without ATOMIK_TX_CHECKSUM_EN, send exactly four bytes per word and build no checksum logic.

Verification
REQ-032 Push 32'hAABBCCDD after reset (no macro) -> uart_tx low 2 edges later; bytes AA,BB,CC,DD decoded at 234 cycles/bit; tx_busy low after 4*2340 cycles.
REQ-033 With ATOMIK_TX_CHECKSUM_EN, push 32'h12345678 -> bytes 12,34,56,78,08.
REQ-034 Hold data_valid high with 6 distinct words while the line is busy (FIFO_DEPTH=4) -> data_ready low once full; overflow=1; the surviving words are sent in order with none duplicated.
REQ-035 Push while a pop occurs in the same cycle (FIFO at 2) -> level stays 2; output order matches push order.
REQ-036 Assert rst_n=0 for 1 cycle during the DATA bit 3 of byte 2 -> uart_tx=1 on the reset edge; FIFO empty; overflow=0; no further start bits until a new push.

Source files
------------

// File: rtl/atomik_uart_tx_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : atomik_uart_tx_streamer                                    |
// | Description : Buffers 32-bit result words in a small FIFO and streams    |
// |               them MSB byte first over an 8N1 UART line.                 |
// | Option      : ATOMIK_TX_CHECKSUM_EN appends an XOR checksum byte per     |
// |               word.                                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module atomik_uart_tx_streamer #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;
`ifdef ATOMIK_TX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif
  localparam int SH_W = 8 * NBYTES;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(NBYTES - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_next;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Serializer state
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;
  logic [SH_W-1:0]  shreg;
  logic [SH_W-1:0]  frame_word;
  logic [7:0]       cur_byte;
  logic             cnt_done;
  logic             last_byte;

  assign fifo_empty = (level == '0);
  // data_ready mirrors ~full from the register, so a push never lands on a full FIFO
  assign push       = data_valid & data_ready;
  assign cnt_done   = (cnt == DIV_LAST);
  assign last_byte  = (byte_idx == LAST_BYTE);
  assign cur_byte   = shreg[SH_W-1 -: 8];

  // Pop the head word when idle, or straight out of the final stop bit so frames stay back-to-back
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if ((state == STOP) && cnt_done && last_byte) begin
        pop = 1'b1;
      end
    end
  end

  // Occupancy after this edge; simultaneous push and pop cancel out
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (!push && pop) begin
      level_next = level - 1'b1;
    end
  end

  // Word to load into the shifter: the head word, optionally followed by its XOR checksum
  always_comb begin
`ifdef ATOMIK_TX_CHECKSUM_EN
    frame_word = {mem[rd_ptr],
                  mem[rd_ptr][31:24] ^ mem[rd_ptr][23:16] ^
                  mem[rd_ptr][15:8]  ^ mem[rd_ptr][7:0]};
`else
    frame_word = mem[rd_ptr];
`endif
  end

  // FIFO data array, written without reset so it can map onto plain storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, level, registered ready and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      data_ready <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level      <= level_next;
      data_ready <= (level_next != DEPTH_LVL);
      if (data_valid && !data_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer; uart_tx is registered from the current state, trailing it by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= cur_byte[bit_idx];
        default: uart_tx <= 1'b1;
      endcase

      tx_busy <= !fifo_empty || (state != IDLE);

      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= frame_word;
            byte_idx <= '0;
            cnt      <= '0;
            state    <= START;
          end
        end
        START: begin
          if (cnt_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt_done) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt_done) begin
            cnt <= '0;
            if (!last_byte) begin
              shreg    <= {shreg[SH_W-9:0], 8'h00};
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
            end else if (pop) begin
              shreg    <= frame_word;
              byte_idx <= '0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
